// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the
// ALU writeback path and the memory load path. Writes to r0 are absorbed
// without taking the port; a saturating counter tracks contended cycles.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_src,
    output logic [CNT_W-1:0]  contention_cnt
);

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    logic last_grant;
    logic alu_comp;
    logic mem_comp;
    logic alu_zero;
    logic mem_zero;
    logic grant_alu;
    logic grant_mem;
    logic contend;

    // Classify requests and pick at most one competing winner; r0 writes are
    // acknowledged unconditionally since they never reach the register file.
    always_comb begin
        alu_comp  = alu_valid && (alu_reg != '0);
        mem_comp  = mem_valid && (mem_reg != '0);
        alu_zero  = alu_valid && (alu_reg == '0);
        mem_zero  = mem_valid && (mem_reg == '0);
        contend   = !hold && alu_comp && mem_comp;
        grant_alu = !hold && alu_comp && (!mem_comp || (last_grant == SRC_MEM));
        grant_mem = !hold && mem_comp && (!alu_comp || (last_grant == SRC_ALU));
        alu_ready = alu_zero || grant_alu;
        mem_ready = mem_zero || grant_mem;
    end

    // Round-robin pointer; reset to MEM so the ALU wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= SRC_MEM;
        end else if (grant_alu) begin
            last_grant <= SRC_ALU;
        end else if (grant_mem) begin
            last_grant <= SRC_MEM;
        end
    end

    // Registered write port; address/data/source hold when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we         <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            rf_src        <= SRC_ALU;
        end else if (grant_alu || grant_mem) begin
            rf_we         <= 1'b1;
            rf_write_reg  <= grant_mem ? mem_reg  : alu_reg;
            rf_write_data <= grant_mem ? mem_data : alu_data;
            rf_src        <= grant_mem;
        end else begin
            rf_we         <= 1'b0;
        end
    end

    // Saturating count of cycles in which both sources competed for the port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contention_cnt <= '0;
        end else if (contend && (contention_cnt != '1)) begin
            contention_cnt <= contention_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clock;
    logic          reset;
    logic          hold;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_reg;
    logic [DW-1:0] mem_data;
    logic          rf_we;
    logic [AW-1:0] rf_write_reg;
    logic [DW-1:0] rf_write_data;
    logic          rf_src;
    logic [CW-1:0] contention_cnt;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .hold           (hold),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_reg        (alu_reg),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_reg        (mem_reg),
        .mem_data       (mem_data),
        .rf_we          (rf_we),
        .rf_write_reg   (rf_write_reg),
        .rf_write_data  (rf_write_data),
        .rf_src         (rf_src),
        .contention_cnt (contention_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: who was served last, and what the write port shows.
    int          m_last;      // 0 = ALU, 1 = MEM
    logic        m_we;
    logic [31:0] m_reg;
    logic [31:0] m_data;
    logic        m_src;
    int          m_cnt;
    int          m_win;       // -1 none, 0 ALU, 1 MEM
    bit          m_both;
    logic        exp_ar;
    logic        exp_mr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_last = 1;
        m_we   = 1'b0;
        m_reg  = '0;
        m_data = '0;
        m_src  = 1'b0;
        m_cnt  = 0;
    endtask

    // Who wants the port (non-r0 valid requests) and who gets it.
    task automatic predict();
        bit want [2];
        want[0] = alu_valid && (alu_reg != 0);
        want[1] = mem_valid && (mem_reg != 0);
        m_both  = !hold && want[0] && want[1];
        m_win   = -1;
        if (!hold) begin
            if (want[0] && want[1]) m_win = 1 - m_last;
            else if (want[0])       m_win = 0;
            else if (want[1])       m_win = 1;
        end
        exp_ar = (alu_valid && alu_reg == 0) || (m_win == 0);
        exp_mr = (mem_valid && mem_reg == 0) || (m_win == 1);
    endtask

    task automatic check_outputs();
        check("rf_we",          32'(rf_we),          32'(m_we));
        check("rf_write_reg",   32'(rf_write_reg),   m_reg);
        check("rf_write_data",  rf_write_data,       m_data);
        check("rf_src",         32'(rf_src),         32'(m_src));
        check("contention_cnt", 32'(contention_cnt), 32'(m_cnt));
    endtask

    // One clock: check the combinational readies, step the model on the edge,
    // then check the registered outputs just after it.
    task automatic cycle();
        #1;
        predict();
        check("alu_ready", 32'(alu_ready), 32'(exp_ar));
        check("mem_ready", 32'(mem_ready), 32'(exp_mr));
        @(posedge clock);
        if (m_win >= 0) begin
            m_we   = 1'b1;
            m_reg  = (m_win == 1) ? 32'(mem_reg)  : 32'(alu_reg);
            m_data = (m_win == 1) ? mem_data      : alu_data;
            m_src  = (m_win == 1);
            m_last = m_win;
        end else begin
            m_we = 1'b0;
        end
        if (m_both && m_cnt < CNT_MAX) m_cnt++;
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        hold      = 1'b0;
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_reg   = '0;
        mem_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        do_reset();

        // Single ALU write, one cycle latency.
        alu_valid = 1'b1; alu_reg = 3'd3; alu_data = 32'h1111_1111;
        cycle();
        check("t1_we",   32'(rf_we),        32'd1);
        check("t1_reg",  32'(rf_write_reg), 32'd3);
        check("t1_data", rf_write_data,     32'h1111_1111);
        check("t1_src",  32'(rf_src),       32'd0);
        idle_inputs();
        cycle();

        // Sustained contention alternates ALU, MEM, ALU, MEM.
        do_reset();
        alu_valid = 1'b1; alu_reg = 3'd1; alu_data = 32'hA;
        mem_valid = 1'b1; mem_reg = 3'd2; mem_data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_src", 32'(rf_src), 32'(i % 2));
        end
        check("rr_cnt", 32'(contention_cnt), 32'd4);

        // Hold blocks both competitors; release resumes with ALU (MEM was last).
        hold = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("hold_cnt", 32'(contention_cnt), 32'd4);
        hold = 1'b0;
        cycle();
        check("release_src", 32'(rf_src), 32'd0);

        // r0 discard alongside a MEM write to r5.
        alu_reg = 3'd0; mem_reg = 3'd5; mem_data = 32'h55;
        cycle();
        check("r0_reg", 32'(rf_write_reg), 32'd5);
        check("r0_src", 32'(rf_src),       32'd1);
        check("r0_cnt", 32'(contention_cnt), 32'd5);
        idle_inputs();
        cycle();

        // Same destination from both: ALU value then MEM value lands in r4.
        do_reset();
        alu_valid = 1'b1; alu_reg = 3'd4; alu_data = 32'h1;
        mem_valid = 1'b1; mem_reg = 3'd4; mem_data = 32'h2;
        cycle();
        check("same_first", rf_write_data, 32'h1);
        alu_valid = 1'b0;
        cycle();
        check("same_final", rf_write_data, 32'h2);
        idle_inputs();

        // Counter saturation, then asynchronous reset mid-burst.
        do_reset();
        alu_valid = 1'b1; alu_reg = 3'd6; alu_data = 32'h66;
        mem_valid = 1'b1; mem_reg = 3'd7; mem_data = 32'h77;
        for (int i = 0; i < 18; i++) cycle();
        check("sat_cnt", 32'(contention_cnt), 32'd15);
        #2;
        reset = 1'b1;
        #1;
        check("async_we",  32'(rf_we),          32'd0);
        check("async_cnt", 32'(contention_cnt), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle();
        check("post_rst_src", 32'(rf_src), 32'd0);

        // Randomized traffic; a stalled requester keeps its request stable.
        for (int i = 0; i < 400; i++) begin
            if (!(alu_valid && !exp_ar)) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_reg   = AW'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!(mem_valid && !exp_mr)) begin
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_reg   = AW'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            hold = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 8x32 register file between two writeback requesters: the ALU result path and the memory load path. Arbitrates each cycle with round-robin priority and valid/ready handshakes, and presents one registered write per cycle on the register file's RegWrite / write_reg / write_data inputs. Discards writes to r0 without consuming a port slot, and keeps a saturating contention counter for performance debug.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 3, register index width (2**ADDR_W registers)
CNT_W, 16, width of contention counter

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
hold  input  1  when 1, no request is granted this cycle (r0 discards still accepted)
alu_valid  input  1  ALU writeback request present
alu_ready  output  1  ALU request accepted this cycle (combinational)
alu_reg  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load writeback request present
mem_ready  output  1  load request accepted this cycle (combinational)
mem_reg  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
rf_we  output  1  to register file RegWrite (registered)
rf_write_reg  output  ADDR_W  to register file write_reg (registered)
rf_write_data  output  DATA_W  to register file write_data (registered)
rf_src  output  1  source of current rf write: 0 = ALU, 1 = MEM (registered)
contention_cnt  output  CNT_W  cycles where both sources competed (registered)

Behaviour:
- Reset (async, immediate): rf_we=0, rf_write_reg=0, rf_write_data=0, rf_src=0, contention_cnt=0, last_grant=MEM (so ALU wins the first tie).
- Transfer occurs on a source when valid && ready in the same cycle; source must hold reg/data stable while valid && !ready.
- r0 discard: a valid request with reg==0 gets ready=1 in that cycle regardless of hold or the other source; it never drives rf_we, never changes last_grant, never counts as contention.
- Competing request: valid with reg!=0. With hold=0:
  - one competing source: it is granted.
  - two competing sources: grant the source != last_grant; contention_cnt increments (saturates at all-ones, no wrap).
  - with hold=1: no competing request is granted; contention_cnt unchanged.
- Grant updates last_grant to the granted source on that rising edge.
- Output stage, on each rising edge: if a competing grant occurred, rf_we=1, rf_write_reg/rf_write_data/rf_src = granted source's values; otherwise rf_we=0, rf_write_reg/rf_write_data/rf_src hold previous values.
- Latency: granted request appears on rf_* exactly 1 cycle after acceptance; register file commits it on the following edge. Throughput: one write per cycle, sustained.
- Same destination from both sources in one cycle: round-robin order decides; the loser is written the next cycle (it wins, as last_grant flipped), so its value ends up final.
- Starvation bound: a continuously valid competing source is granted within 2 cycles once hold=0.
- ready never depends on the requester's own ready; no combinational path from rf_* to inputs.
- Reset mid-operation: pending output write is dropped (rf_we=0 immediately); un-accepted requests are simply re-arbitrated after reset deasserts.

Test Plan:
- After reset, alu_valid=1 alu_reg=3 alu_data=0x11111111 for one cycle -> alu_ready=1 same cycle; next cycle rf_we=1, rf_write_reg=3, rf_write_data=0x11111111, rf_src=0.
- Both valid every cycle (alu r1=0xA, mem r2=0xB) for 4 cycles -> grants ALU,MEM,ALU,MEM; rf_src 0,1,0,1; contention_cnt=4.
- alu_reg=0 and mem_reg=5 both valid same cycle -> alu_ready=1 and mem_ready=1; next cycle rf_we=1, rf_write_reg=5, rf_src=1; contention_cnt unchanged.
- hold=1 with both sources valid (non-zero regs) for 3 cycles -> both ready=0, rf_we=0, contention_cnt unchanged; release hold -> round-robin resumes with the source != last_grant.
- Both target r4 (alu 0x1, mem 0x2) held valid, last_grant=MEM -> rf writes r4=0x1 then r4=0x2 on consecutive cycles.
- Force contention_cnt to all-ones with CNT_W=4 (15 contended cycles, then 3 more) -> stays 15; assert reset mid-burst -> rf_we=0 and counter=0 asynchronously.
